// File: rtl/ac97_frame_driver.sv
// ac97_frame_driver: frame-level producer for the AC'97 link serializer.
// After reset it waits a fixed number of frames for the codec to settle.
// It then writes three codec registers on slots 1/2.
// After that it streams stereo PCM from an internal FIFO onto slots 3/4.
`timescale 1ns/1ps
module ac97_frame_driver #(
    parameter int FIFO_DEPTH_LOG2  = 4,
    parameter int INIT_WAIT_FRAMES = 255
) (
    input  logic                       ac97_bitclk,
    input  logic                       rst_b,
    input  logic                       ac97_strobe,
    input  logic signed [15:0]         sample_l,
    input  logic signed [15:0]         sample_r,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    output logic [19:0]                ac97_out_slot1,
    output logic [19:0]                ac97_out_slot2,
    output logic [19:0]                ac97_out_slot3,
    output logic [19:0]                ac97_out_slot4,
    output logic                       ac97_out_slot1_valid,
    output logic                       ac97_out_slot2_valid,
    output logic                       ac97_out_slot3_valid,
    output logic                       ac97_out_slot4_valid,
    output logic                       init_done,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
    output logic [15:0]                underrun_count
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [15:0] WAIT_LAST = 16'(INIT_WAIT_FRAMES);
    localparam logic [FIFO_DEPTH_LOG2:0]   LVL_FULL = (FIFO_DEPTH_LOG2+1)'(DEPTH);
    localparam logic [FIFO_DEPTH_LOG2:0]   LVL_ONE  = (FIFO_DEPTH_LOG2+1)'(1);
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = FIFO_DEPTH_LOG2'(1);

    typedef enum logic [1:0] {S_WAIT = 2'd0, S_CMD = 2'd1, S_STREAM = 2'd2} state_t;

    // Codec register writes issued once after the settle delay.
    function automatic logic [19:0] cmd_slot1(input logic [1:0] idx);
        logic [6:0] addr;
        case (idx)
            2'd0:    addr = 7'h02;
            2'd1:    addr = 7'h04;
            2'd2:    addr = 7'h18;
            default: addr = 7'h00;
        endcase
        return {1'b0, addr, 12'h000};
    endfunction

    function automatic logic [19:0] cmd_slot2(input logic [1:0] idx);
        logic [15:0] data;
        case (idx)
            2'd2:    data = 16'h0808;
            default: data = 16'h0000;
        endcase
        return {data, 4'h0};
    endfunction

    // 16-bit PCM is left-justified in the 20-bit slot.
    function automatic logic [19:0] pcm_slot(input logic signed [15:0] s);
        return {s, 4'h0};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t                     state, state_nxt;
    logic [15:0]                frame_cnt, frame_cnt_nxt;
    logic [1:0]                 cmd_idx, cmd_idx_nxt;
    logic                       cmd_load;
    logic                       stream_frame;

    logic [31:0]                mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                       full, empty, push, pop;
    logic [31:0]                head;

    assign full         = (fifo_level == LVL_FULL);
    assign empty        = (fifo_level == '0);
    assign sample_ready = rst_b && !full;
    assign push         = sample_valid && sample_ready;
    assign pop          = stream_frame && !empty;
    assign head         = mem[rd_ptr];

    // Next-state logic: everything advances only on a frame strobe.
    always_comb begin
        state_nxt     = state;
        frame_cnt_nxt = frame_cnt;
        cmd_idx_nxt   = cmd_idx;
        cmd_load      = 1'b0;
        stream_frame  = 1'b0;
        if (ac97_strobe) begin
            case (state)
                S_WAIT: begin
                    if (frame_cnt == WAIT_LAST) begin
                        state_nxt   = S_CMD;
                        cmd_idx_nxt = 2'd0;
                        cmd_load    = 1'b1;
                    end else begin
                        frame_cnt_nxt = frame_cnt + 16'd1;
                    end
                end
                S_CMD: begin
                    if (cmd_idx == 2'd2) begin
                        state_nxt    = S_STREAM;
                        stream_frame = 1'b1;
                    end else begin
                        cmd_idx_nxt = cmd_idx + 2'd1;
                        cmd_load    = 1'b1;
                    end
                end
                S_STREAM: stream_frame = 1'b1;
                default:  state_nxt = S_WAIT;
            endcase
        end
    end

    // State register.
    always_ff @(posedge ac97_bitclk) begin
        if (!rst_b) begin
            state     <= S_WAIT;
            frame_cnt <= 16'd0;
            cmd_idx   <= 2'd0;
        end else begin
            state     <= state_nxt;
            frame_cnt <= frame_cnt_nxt;
            cmd_idx   <= cmd_idx_nxt;
        end
    end

    // FIFO storage; contents need no reset, pointers and level do.
    always_ff @(posedge ac97_bitclk) begin
        if (push) mem[wr_ptr] <= {sample_l, sample_r};
    end

    // FIFO pointers and exact occupancy; the level is unchanged on a simultaneous push and pop.
    always_ff @(posedge ac97_bitclk) begin
        if (!rst_b) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_ONE;
                2'b01:   fifo_level <= fifo_level - LVL_ONE;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Slot outputs are registered at the strobe and held for the whole frame.
    always_ff @(posedge ac97_bitclk) begin
        if (!rst_b) begin
            ac97_out_slot1       <= 20'd0;
            ac97_out_slot2       <= 20'd0;
            ac97_out_slot3       <= 20'd0;
            ac97_out_slot4       <= 20'd0;
            ac97_out_slot1_valid <= 1'b0;
            ac97_out_slot2_valid <= 1'b0;
            ac97_out_slot3_valid <= 1'b0;
            ac97_out_slot4_valid <= 1'b0;
            init_done            <= 1'b0;
            underrun_count       <= 16'd0;
        end else if (ac97_strobe) begin
            ac97_out_slot1       <= cmd_load ? cmd_slot1(cmd_idx_nxt) : 20'd0;
            ac97_out_slot2       <= cmd_load ? cmd_slot2(cmd_idx_nxt) : 20'd0;
            ac97_out_slot1_valid <= cmd_load;
            ac97_out_slot2_valid <= cmd_load;
            ac97_out_slot3       <= pop ? pcm_slot(head[31:16]) : 20'd0;
            ac97_out_slot4       <= pop ? pcm_slot(head[15:0])  : 20'd0;
            ac97_out_slot3_valid <= pop;
            ac97_out_slot4_valid <= pop;
            init_done            <= (state_nxt == S_STREAM);
            if (stream_frame && empty) underrun_count <= sat_inc(underrun_count);
        end
    end

endmodule

// File: tb/tb_ac97_frame_driver.sv
// Scoreboard bench for ac97_frame_driver (INIT_WAIT_FRAMES=2, 4-entry FIFO).
`timescale 1ns/1ps
module tb_ac97_frame_driver;

    logic               clk = 1'b0;
    logic               rst_b;
    logic               strobe;
    logic signed [15:0] sample_l, sample_r;
    logic               sample_valid;
    logic               sample_ready;
    logic [19:0]        s1, s2, s3, s4;
    logic               v1, v2, v3, v4;
    logic               init_done;
    logic [2:0]         fifo_level;
    logic [15:0]        underrun_count;

    always #5 clk = ~clk;

    ac97_frame_driver #(.FIFO_DEPTH_LOG2(2), .INIT_WAIT_FRAMES(2)) dut (
        .ac97_bitclk(clk), .rst_b(rst_b), .ac97_strobe(strobe),
        .sample_l(sample_l), .sample_r(sample_r), .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .ac97_out_slot1(s1), .ac97_out_slot2(s2), .ac97_out_slot3(s3), .ac97_out_slot4(s4),
        .ac97_out_slot1_valid(v1), .ac97_out_slot2_valid(v2),
        .ac97_out_slot3_valid(v3), .ac97_out_slot4_valid(v4),
        .init_done(init_done), .fifo_level(fifo_level), .underrun_count(underrun_count)
    );

    typedef struct {
        logic [19:0] s1, s2, s3, s4;
        logic [3:0]  v;     // {slot4, slot3, slot2, slot1}
        logic        init;
        logic [15:0] urun;
        int          level;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_idle(input int level);
        exp_t e = '{default: 0};
        e.level = level;
        return e;
    endfunction

    function automatic exp_t mk_cmd(input logic [19:0] a, input logic [19:0] d, input int level);
        exp_t e = '{default: 0};
        e.s1 = a; e.s2 = d; e.v = 4'b0011; e.level = level;
        return e;
    endfunction

    function automatic exp_t mk_stream(input logic [19:0] l, input logic [19:0] r, input logic vld,
                                       input logic [15:0] urun, input int level);
        exp_t e = '{default: 0};
        e.s3 = l; e.s4 = r; e.v = {vld, vld, 2'b00}; e.init = 1'b1;
        e.urun = urun; e.level = level;
        return e;
    endfunction

    // Monitor: every strobe edge produces one frame, compared against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (strobe === 1'b1 && rst_b === 1'b1) begin
                #1;
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_frame actual=frame required=none t=%0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("slot1", s1, e.s1);
                    chk("slot2", s2, e.s2);
                    chk("slot3", s3, e.s3);
                    chk("slot4", s4, e.s4);
                    chk("valids", {v4, v3, v2, v1}, e.v);
                    chk("init_done", init_done, e.init);
                    chk("underrun", underrun_count, e.urun);
                    chk("level", fifo_level, e.level);
                end
            end
        end
    end

    task automatic frame(input int gap, input exp_t e, input bit push,
                         input logic [15:0] l, input logic [15:0] r);
        repeat (gap) @(negedge clk);
        sb.push_back(e);
        strobe = 1'b1;
        if (push) begin sample_valid = 1'b1; sample_l = l; sample_r = r; end
        @(negedge clk);
        strobe = 1'b0;
        if (push) sample_valid = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, sample_ready, 0);
        chk({tag, "_slots"}, {s1, s2, s3, s4} == 80'd0, 1);
        chk({tag, "_valids"}, {v4, v3, v2, v1}, 0);
        chk({tag, "_init"}, init_done, 0);
        chk({tag, "_level"}, fifo_level, 0);
        chk({tag, "_urun"}, underrun_count, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b = 1'b0; strobe = 1'b0; sample_valid = 1'b0; sample_l = '0; sample_r = '0;
        @(negedge clk);
        repeat (4) @(negedge clk);
        chk_reset_state("rst0");
        rst_b = 1'b1;

        // Two samples pushed during WAIT.
        sample_valid = 1'b1; sample_l = 16'h1234; sample_r = 16'hABCD;
        @(negedge clk);
        sample_l = 16'h0001; sample_r = 16'hFFFF;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("wait_level", fifo_level, 2);
        chk("wait_ready", sample_ready, 1);

        // Settle, commands, then stream, strobes every 256 cycles.
        frame(254, mk_idle(2), 0, 0, 0);
        frame(255, mk_idle(2), 0, 0, 0);
        frame(255, mk_cmd(20'h02000, 20'h00000, 2), 0, 0, 0);
        frame(255, mk_cmd(20'h04000, 20'h00000, 2), 0, 0, 0);
        frame(255, mk_cmd(20'h18000, 20'h08080, 2), 0, 0, 0);
        frame(255, mk_stream(20'h12340, 20'hABCD0, 1, 0, 1), 0, 0, 0);
        frame(255, mk_stream(20'h00010, 20'hFFFF0, 1, 0, 0), 0, 0, 0);

        // Underruns, then a push coinciding with the strobe.
        frame(15, mk_stream(0, 0, 0, 1, 0), 0, 0, 0);
        frame(15, mk_stream(0, 0, 0, 2, 0), 0, 0, 0);
        frame(15, mk_stream(0, 0, 0, 3, 0), 0, 0, 0);
        frame(15, mk_stream(0, 0, 0, 4, 1), 1, 16'h8000, 16'h7FFF);
        frame(15, mk_stream(20'h80000, 20'h7FFF0, 1, 4, 0), 0, 0, 0);

        // Three samples queued, then a one-cycle reset.
        sample_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sample_l = 16'h0555; sample_r = 16'h0666;
            @(negedge clk);
        end
        sample_valid = 1'b0;
        chk("pre_reset_level", fifo_level, 3);
        rst_b = 1'b0;
        @(negedge clk);
        chk_reset_state("rst1");
        rst_b = 1'b1;

        // Fill to full in WAIT while holding sample_valid.
        sample_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sample_l = 16'h0100 + 16'(k); sample_r = 16'h0200 + 16'(k);
            @(negedge clk);
        end
        sample_l = 16'h0AAA; sample_r = 16'h0BBB;
        repeat (2) @(negedge clk);
        chk("full_ready", sample_ready, 0);
        chk("full_level", fifo_level, 4);

        frame(15, mk_idle(4), 0, 0, 0);
        frame(15, mk_idle(4), 0, 0, 0);
        frame(15, mk_cmd(20'h02000, 20'h00000, 4), 0, 0, 0);
        frame(15, mk_cmd(20'h04000, 20'h00000, 4), 0, 0, 0);
        frame(15, mk_cmd(20'h18000, 20'h08080, 4), 0, 0, 0);
        frame(15, mk_stream(20'h01000, 20'h02000, 1, 0, 3), 0, 0, 0);
        @(negedge clk);
        sample_valid = 1'b0;
        chk("refill_level", fifo_level, 4);
        chk("refill_ready", sample_ready, 0);
        frame(15, mk_stream(20'h01010, 20'h02010, 1, 0, 3), 0, 0, 0);
        frame(15, mk_stream(20'h01020, 20'h02020, 1, 0, 2), 0, 0, 0);
        frame(15, mk_stream(20'h01030, 20'h02030, 1, 0, 1), 0, 0, 0);
        frame(15, mk_stream(20'h0AAA0, 20'h0BBB0, 1, 0, 0), 0, 0, 0);
        frame(15, mk_stream(0, 0, 0, 1, 0), 0, 0, 0);

        // Saturation: strobe on every cycle.
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        frame(0, mk_idle(0), 0, 0, 0);
        frame(0, mk_idle(0), 0, 0, 0);
        frame(0, mk_cmd(20'h02000, 20'h00000, 0), 0, 0, 0);
        frame(0, mk_cmd(20'h04000, 20'h00000, 0), 0, 0, 0);
        frame(0, mk_cmd(20'h18000, 20'h08080, 0), 0, 0, 0);
        for (int i = 1; i <= 65540; i++)
            frame(0, mk_stream(0, 0, 0, (i > 65535) ? 16'hFFFF : 16'(i), 0), 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("sat_urun", underrun_count, 16'hFFFF);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
